// File: rtl/hough_lane_select_if.sv
// rtl/hough_lane_select_if.sv - accumulator read port between lane selector and vote memory
interface hough_lane_select_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] accum_rd_addr;
    logic [DATA_W-1:0] accum_rd_data;

    modport master (output accum_rd_addr, input accum_rd_data);
    modport slave  (input accum_rd_addr, output accum_rd_data);
endinterface

// File: rtl/hough_lane_select.sv
// rtl/hough_lane_select.sv - single-pass scan of the Hough accumulator picking the strongest
// left-band and right-band lines
module hough_lane_select #(
    parameter int RHO_RANGE       = 1024,
    parameter int THETAS          = 180,
    parameter int ACCUM_WIDTH     = 16,
    parameter int LEFT_THETA_MIN  = 20,
    parameter int LEFT_THETA_MAX  = 70,
    parameter int RIGHT_THETA_MIN = 110,
    parameter int RIGHT_THETA_MAX = 160,
    parameter int VOTE_THRESH     = 32,
    localparam int ADDR_W = $clog2(RHO_RANGE * THETAS),
    localparam int RHO_W  = $clog2(RHO_RANGE),
    localparam int TH_W   = $clog2(THETAS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    hough_lane_select_if.master    acc,
    output logic [RHO_W-1:0]       left_rho,
    output logic [TH_W-1:0]        left_theta,
    output logic [ACCUM_WIDTH-1:0] left_votes,
    output logic                   left_found,
    output logic [RHO_W-1:0]       right_rho,
    output logic [TH_W-1:0]        right_theta,
    output logic [ACCUM_WIDTH-1:0] right_votes,
    output logic                   right_found,
    output logic                   done
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [RHO_W-1:0]       RHO_LAST = RHO_W'(RHO_RANGE - 1);
    localparam logic [TH_W-1:0]        TH_LAST  = TH_W'(THETAS - 1);
    localparam logic [ACCUM_WIDTH-1:0] THRESH   = ACCUM_WIDTH'(VOTE_THRESH);

    state_t                 state_q, state_d;
    logic                   start_q, start_d;
    logic [RHO_W-1:0]       rho_q, rho_d;
    logic [TH_W-1:0]        theta_q, theta_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   smp_valid_q, smp_valid_d;
    logic [RHO_W-1:0]       smp_rho_q, smp_rho_d;
    logic [TH_W-1:0]        smp_theta_q, smp_theta_d;
    logic [RHO_W-1:0]       lb_rho_q, lb_rho_d, rb_rho_q, rb_rho_d;
    logic [TH_W-1:0]        lb_theta_q, lb_theta_d, rb_theta_q, rb_theta_d;
    logic [ACCUM_WIDTH-1:0] lb_votes_q, lb_votes_d, rb_votes_q, rb_votes_d;
    logic [RHO_W-1:0]       lo_rho_q, lo_rho_d, ro_rho_q, ro_rho_d;
    logic [TH_W-1:0]        lo_theta_q, lo_theta_d, ro_theta_q, ro_theta_d;
    logic [ACCUM_WIDTH-1:0] lo_votes_q, lo_votes_d, ro_votes_q, ro_votes_d;
    logic                   lo_found_q, lo_found_d, ro_found_q, ro_found_d;
    logic                   done_q, done_d;
    logic                   trigger, in_left, in_right, l_found, r_found;

    always_comb begin
        state_d     = state_q;
        start_d     = start;
        rho_d       = rho_q;
        theta_d     = theta_q;
        addr_d      = addr_q;
        smp_valid_d = 1'b0;
        smp_rho_d   = rho_q;
        smp_theta_d = theta_q;
        lb_rho_d    = lb_rho_q;
        lb_theta_d  = lb_theta_q;
        lb_votes_d  = lb_votes_q;
        rb_rho_d    = rb_rho_q;
        rb_theta_d  = rb_theta_q;
        rb_votes_d  = rb_votes_q;
        lo_rho_d    = lo_rho_q;
        lo_theta_d  = lo_theta_q;
        lo_votes_d  = lo_votes_q;
        lo_found_d  = lo_found_q;
        ro_rho_d    = ro_rho_q;
        ro_theta_d  = ro_theta_q;
        ro_votes_d  = ro_votes_q;
        ro_found_d  = ro_found_q;
        done_d      = 1'b0;
        trigger     = start & ~start_q;

        // Read data lines up with the tags registered one cycle earlier; strict > keeps the first tie.
        in_left  = (smp_theta_q >= TH_W'(LEFT_THETA_MIN))  && (smp_theta_q <= TH_W'(LEFT_THETA_MAX));
        in_right = (smp_theta_q >= TH_W'(RIGHT_THETA_MIN)) && (smp_theta_q <= TH_W'(RIGHT_THETA_MAX));
        if (smp_valid_q && in_left && (acc.accum_rd_data > lb_votes_q)) begin
            lb_rho_d   = smp_rho_q;
            lb_theta_d = smp_theta_q;
            lb_votes_d = acc.accum_rd_data;
        end
        if (smp_valid_q && in_right && (acc.accum_rd_data > rb_votes_q)) begin
            rb_rho_d   = smp_rho_q;
            rb_theta_d = smp_theta_q;
            rb_votes_d = acc.accum_rd_data;
        end
        l_found = (lb_votes_d >= THRESH);
        r_found = (rb_votes_d >= THRESH);

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d    = S_SCAN;
                    rho_d      = '0;
                    theta_d    = '0;
                    addr_d     = '0;
                    lb_rho_d   = '0;
                    lb_theta_d = '0;
                    lb_votes_d = '0;
                    rb_rho_d   = '0;
                    rb_theta_d = '0;
                    rb_votes_d = '0;
                end
            end
            S_SCAN: begin
                smp_valid_d = 1'b1;
                if (theta_q == TH_LAST) begin
                    theta_d = '0;
                    if (rho_q == RHO_LAST) begin
                        rho_d   = '0;
                        addr_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        rho_d  = rho_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    theta_d = theta_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Load from the _d values so the final read sample is included.
                state_d    = S_DONE;
                done_d     = 1'b1;
                lo_found_d = l_found;
                lo_rho_d   = l_found ? lb_rho_d   : '0;
                lo_theta_d = l_found ? lb_theta_d : '0;
                lo_votes_d = l_found ? lb_votes_d : '0;
                ro_found_d = r_found;
                ro_rho_d   = r_found ? rb_rho_d   : '0;
                ro_theta_d = r_found ? rb_theta_d : '0;
                ro_votes_d = r_found ? rb_votes_d : '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            rho_q       <= '0;
            theta_q     <= '0;
            addr_q      <= '0;
            smp_valid_q <= 1'b0;
            smp_rho_q   <= '0;
            smp_theta_q <= '0;
            lb_rho_q    <= '0;
            lb_theta_q  <= '0;
            lb_votes_q  <= '0;
            rb_rho_q    <= '0;
            rb_theta_q  <= '0;
            rb_votes_q  <= '0;
            lo_rho_q    <= '0;
            lo_theta_q  <= '0;
            lo_votes_q  <= '0;
            lo_found_q  <= 1'b0;
            ro_rho_q    <= '0;
            ro_theta_q  <= '0;
            ro_votes_q  <= '0;
            ro_found_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            rho_q       <= rho_d;
            theta_q     <= theta_d;
            addr_q      <= addr_d;
            smp_valid_q <= smp_valid_d;
            smp_rho_q   <= smp_rho_d;
            smp_theta_q <= smp_theta_d;
            lb_rho_q    <= lb_rho_d;
            lb_theta_q  <= lb_theta_d;
            lb_votes_q  <= lb_votes_d;
            rb_rho_q    <= rb_rho_d;
            rb_theta_q  <= rb_theta_d;
            rb_votes_q  <= rb_votes_d;
            lo_rho_q    <= lo_rho_d;
            lo_theta_q  <= lo_theta_d;
            lo_votes_q  <= lo_votes_d;
            lo_found_q  <= lo_found_d;
            ro_rho_q    <= ro_rho_d;
            ro_theta_q  <= ro_theta_d;
            ro_votes_q  <= ro_votes_d;
            ro_found_q  <= ro_found_d;
            done_q      <= done_d;
        end
    end

    assign acc.accum_rd_addr = addr_q;
    assign left_rho          = lo_rho_q;
    assign left_theta        = lo_theta_q;
    assign left_votes        = lo_votes_q;
    assign left_found        = lo_found_q;
    assign right_rho         = ro_rho_q;
    assign right_theta       = ro_theta_q;
    assign right_votes       = ro_votes_q;
    assign right_found       = ro_found_q;
    assign done              = done_q;
endmodule

// File: tb/tb_hough_lane_select.sv
// tb/tb_hough_lane_select.sv - randomized and directed bench for hough_lane_select
module tb_hough_lane_select;
    localparam int RR = 4;
    localparam int TH = 8;
    localparam int N  = RR * TH;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  left_rho, right_rho;
    logic [2:0]  left_theta, right_theta;
    logic [15:0] left_votes, right_votes;
    logic        left_found, right_found, done;

    int checks = 0;
    int errors = 0;
    int mem [N];
    int e_lr, e_lt, e_lv, e_lf, e_rr, e_rt, e_rv, e_rf;

    hough_lane_select_if #(.ADDR_W(5), .DATA_W(16)) acc_if ();

    hough_lane_select #(
        .RHO_RANGE(RR), .THETAS(TH), .ACCUM_WIDTH(16),
        .LEFT_THETA_MIN(1), .LEFT_THETA_MAX(3),
        .RIGHT_THETA_MIN(5), .RIGHT_THETA_MAX(7), .VOTE_THRESH(10)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .acc(acc_if),
        .left_rho(left_rho), .left_theta(left_theta), .left_votes(left_votes),
        .left_found(left_found), .right_rho(right_rho), .right_theta(right_theta),
        .right_votes(right_votes), .right_found(right_found), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) acc_if.accum_rd_data <= 16'(mem[acc_if.accum_rd_addr]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic band_best(input int tmin, input int tmax,
                             output int br, output int bt, output int bv, output int bf);
        br = 0; bt = 0; bv = 0;
        for (int r = 0; r < RR; r++)
            for (int t = tmin; t <= tmax; t++)
                if (mem[r*TH + t] > bv) begin
                    br = r; bt = t; bv = mem[r*TH + t];
                end
        bf = (bv >= 10) ? 1 : 0;
        if (bf == 0) begin
            br = 0; bt = 0; bv = 0;
        end
    endtask

    task automatic fill(input int lo, input int hi);
        for (int i = 0; i < N; i++) mem[i] = $urandom_range(hi, lo);
    endtask

    task automatic run_and_check(input string name);
        int n;
        bit seen;
        band_best(1, 3, e_lr, e_lt, e_lv, e_lf);
        band_best(5, 7, e_rr, e_rt, e_rv, e_rf);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (done) seen = 1;
        end
        check({name, " latency"}, n, N + 1);
        check({name, " left_rho"}, left_rho, e_lr);
        check({name, " left_theta"}, left_theta, e_lt);
        check({name, " left_votes"}, left_votes, e_lv);
        check({name, " left_found"}, left_found, e_lf);
        check({name, " right_rho"}, right_rho, e_rr);
        check({name, " right_theta"}, right_theta, e_rt);
        check({name, " right_votes"}, right_votes, e_rv);
        check({name, " right_found"}, right_found, e_rf);
        @(posedge clock);
        #1;
        check({name, " done_pulse_width"}, done, 0);
        check({name, " addr_idle"}, acc_if.accum_rd_addr, 0);
        start = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        int cnt;
        fill(0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("reset done", done, 0);
        check("reset left_votes", left_votes, 0);
        check("reset right_votes", right_votes, 0);
        check("reset found", {left_found, right_found}, 0);
        check("reset addr", acc_if.accum_rd_addr, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        run_and_check("all_zero");

        for (int i = 0; i < N; i++) mem[i] = 5;
        mem[2*TH + 2] = 40;
        mem[3*TH + 6] = 25;
        run_and_check("directed");
        check("directed left_votes const", left_votes, 40);
        check("directed right_theta const", right_theta, 6);

        fill(0, 0);
        mem[0*TH + 1] = 20;
        mem[3*TH + 3] = 20;
        mem[1*TH + 4] = 99;
        mem[2*TH + 5] = 15;
        run_and_check("tie");
        check("tie left_rho const", left_rho, 0);

        fill(0, 3);
        mem[1*TH + 2] = 12;
        mem[2*TH + 7] = 9;
        run_and_check("right_below");
        check("right_below found const", right_found, 0);

        for (int k = 0; k < 6; k++) begin
            fill(0, (k % 2 == 0) ? 15 : 9);
            run_and_check($sformatf("rand%0d", k));
        end

        // start held high: one scan only
        fill(0, 20);
        cnt = 0;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (done) cnt++;
        end
        check("held_start dones", cnt, 1);
        start = 1'b0;
        repeat (2) @(posedge clock);

        // second rising edge during the scan is ignored
        cnt = 0;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clock);
            #1;
            if (done) cnt++;
            if (i == 8)  start = 1'b0;
            if (i == 11) start = 1'b1;
            if (i == 60) start = 1'b0;
        end
        check("mid_scan_edge dones", cnt, 1);

        // reset in the middle of a scan
        fill(10, 30);
        run_and_check("pre_reset");
        fill(0, 25);
        @(negedge clock);
        start = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort left_votes", left_votes, 0);
        check("abort right_votes", right_votes, 0);
        check("abort found", {left_found, right_found}, 0);
        check("abort addr", acc_if.accum_rd_addr, 0);
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (done) cnt++;
        end
        check("abort no_done", cnt, 0);
        run_and_check("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
